// File: rtl/core_pkg.sv
// Shared definitions for the RV64 core pipeline: register index width,
// forwarding-select encoding, the shadow destination entry kept by the hazard
// controller, and the hit/select helpers built on top of it.
package core_pkg;

    localparam int XREG_W = 5;

    localparam logic [1:0] FWD_NONE = 2'd0;
    localparam logic [1:0] FWD_MEM  = 2'd1;
    localparam logic [1:0] FWD_WB   = 2'd2;

    typedef struct packed {
        logic              valid;
        logic [XREG_W-1:0] rd;
        logic              we;
        logic              is_load;
    } shadow_entry_t;

    localparam shadow_entry_t SHADOW_EMPTY = '{valid: 1'b0, rd: '0, we: 1'b0, is_load: 1'b0};

    // True when entry e will write register r (x0 never counts as a producer).
    function automatic logic entry_hit(input shadow_entry_t e, input logic [XREG_W-1:0] r);
        return e.valid && e.we && (e.rd == r) && (r != '0);
    endfunction

    // True when entry e is a load that writes register r.
    function automatic logic load_hit(input shadow_entry_t e, input logic [XREG_W-1:0] r);
        return entry_hit(e, r) && e.is_load;
    endfunction

    // Operand select for a source that is about to enter EX. ex_e moves to MEM
    // and mem_e moves to WB at the same edge, so an ALU result in ex_e is taken
    // from the MEM path and anything in mem_e from the WB path. Load data only
    // appears on the WB path after the load-use stall has drained the load into
    // wb_e, so a load found there still feeds the consumer through WB.
    function automatic logic [1:0] fwd_sel(input shadow_entry_t ex_e,
                                           input shadow_entry_t mem_e,
                                           input shadow_entry_t wb_e,
                                           input logic [XREG_W-1:0] r);
        if (entry_hit(ex_e, r) && !ex_e.is_load) begin
            return FWD_MEM;
        end
        if (entry_hit(mem_e, r) || load_hit(wb_e, r)) begin
            return FWD_WB;
        end
        return FWD_NONE;
    endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_muldiv_seq.sv
// MUL/DIV occupancy sequencer: once a MUL/DIV op enters EX it keeps the stage
// busy for MULDIV_LAT-1 further cycles, counting down to 1 and then returning
// to IDLE. done marks the final busy cycle.
module muldiv_seq
    import core_pkg::*;
#(
    parameter int MULDIV_LAT = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic start,
    output logic busy,
    output logic done
);

    localparam int CNT_W = (MULDIV_LAT > 2) ? $clog2(MULDIV_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MULDIV_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;

    // State and down-counter: load on start, leave BUSY after the count reaches 1.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_BUSY;
                        cnt   <= CNT_INIT;
                    end
                end
                default: begin
                    if (cnt == CNT_LAST) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign busy = (state == ST_BUSY);
    assign done = busy && (cnt == CNT_LAST);

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Pipeline hazard controller for the RV64 5-stage core. Shadows the EX/MEM/WB
// destinations, produces the registered EX operand forwarding selects, and
// generates load-use / MUL-DIV stalls, ID/EX bubbles and the branch flush.
module fwd_hazard_ctrl
    import core_pkg::*;
#(
    parameter int XREG_W     = 5,
    parameter int MULDIV_LAT = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              id_valid,
    input  logic [XREG_W-1:0] id_rs1,
    input  logic [XREG_W-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [XREG_W-1:0] id_rd,
    input  logic              id_we,
    input  logic              id_is_load,
    input  logic              id_is_muldiv,
    input  logic              id_is_branch,
    input  logic              ex_branch_taken,
    output logic [1:0]        rs1_forwarding,
    output logic [1:0]        rs2_forwarding,
    output logic              stall_if_id,
    output logic              bubble_ex,
    output logic              flush_if_id,
    output logic              muldiv_busy
);

    shadow_entry_t ex_q, mem_q, wb_q;
    shadow_entry_t id_entry;
    logic          load_use;
    logic          flush;
    logic          advance;
    logic          muldiv_start;
    logic          muldiv_done;
    logic [1:0]    rs1_sel_nxt, rs2_sel_nxt;

    assign id_entry = '{valid: id_valid, rd: id_rd, we: id_we, is_load: id_is_load};

    // Detect a used source that depends on a load still in EX or MEM.
    always_comb begin
        load_use = 1'b0;
        if (id_valid) begin
            load_use = (id_use_rs1 && (load_hit(ex_q, id_rs1) || load_hit(mem_q, id_rs1)))
                    || (id_use_rs2 && (load_hit(ex_q, id_rs2) || load_hit(mem_q, id_rs2)));
        end
    end

    // A busy MUL/DIV owns EX: it ignores redirects and suppresses bubbles, and a
    // taken branch squashes whatever sits in ID instead of stalling on it.
    assign flush        = ex_branch_taken && !muldiv_busy;
    assign stall_if_id  = muldiv_busy || (load_use && !flush);
    assign bubble_ex    = !muldiv_busy && (flush || load_use);
    assign flush_if_id  = flush;
    assign advance      = !muldiv_busy && !load_use && !flush;
    assign muldiv_start = advance && id_valid && id_is_muldiv;

    // Select values for the instruction now in ID, zeroed where it does not read
    // the source or where the branch comparator handles its own forwarding.
    always_comb begin
        rs1_sel_nxt = FWD_NONE;
        rs2_sel_nxt = FWD_NONE;
        if (id_valid && !id_is_branch) begin
            if (id_use_rs1) begin
                rs1_sel_nxt = fwd_sel(ex_q, mem_q, wb_q, id_rs1);
            end
            if (id_use_rs2) begin
                rs2_sel_nxt = fwd_sel(ex_q, mem_q, wb_q, id_rs2);
            end
        end
    end

    // Shadow pipe: EX holds while MUL/DIV is busy and MEM receives a hole behind it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ex_q  <= SHADOW_EMPTY;
            mem_q <= SHADOW_EMPTY;
            wb_q  <= SHADOW_EMPTY;
        end else if (muldiv_busy) begin
            mem_q <= SHADOW_EMPTY;
            wb_q  <= mem_q;
        end else begin
            ex_q  <= advance ? id_entry : SHADOW_EMPTY;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    // Forwarding selects follow the instruction into EX; bubbles carry no forwarding.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rs1_forwarding <= FWD_NONE;
            rs2_forwarding <= FWD_NONE;
        end else if (!muldiv_busy) begin
            if (advance) begin
                rs1_forwarding <= rs1_sel_nxt;
                rs2_forwarding <= rs2_sel_nxt;
            end else begin
                rs1_forwarding <= FWD_NONE;
                rs2_forwarding <= FWD_NONE;
            end
        end
    end

    muldiv_seq #(
        .MULDIV_LAT (MULDIV_LAT)
    ) u_muldiv_seq (
        .clk   (clk),
        .rstn  (rstn),
        .start (muldiv_start),
        .busy  (muldiv_busy),
        .done  (muldiv_done)
    );

    // The last busy cycle must always release EX on the following edge.
    a_done_releases : assert property (@(posedge clk) disable iff (!rstn)
                                       muldiv_done |=> !muldiv_busy);

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl: a stage-occupancy model of the
// pipeline is compared against the DUT every cycle, and directed instruction
// sequences pin the model with hand-computed stall counts and selects.
module tb_fwd_hazard_ctrl;

    localparam int LAT = 4;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
    logic       id_we = 1'b0, id_is_load = 1'b0, id_is_muldiv = 1'b0, id_is_branch = 1'b0;
    logic       ex_branch_taken = 1'b0;
    logic [1:0] rs1_forwarding, rs2_forwarding;
    logic       stall_if_id, bubble_ex, flush_if_id, muldiv_busy;

    int checks = 0;
    int errors = 0;

    fwd_hazard_ctrl #(
        .XREG_W     (5),
        .MULDIV_LAT (LAT)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .id_rd           (id_rd),
        .id_we           (id_we),
        .id_is_load      (id_is_load),
        .id_is_muldiv    (id_is_muldiv),
        .id_is_branch    (id_is_branch),
        .ex_branch_taken (ex_branch_taken),
        .rs1_forwarding  (rs1_forwarding),
        .rs2_forwarding  (rs2_forwarding),
        .stall_if_id     (stall_if_id),
        .bubble_ex       (bubble_ex),
        .flush_if_id     (flush_if_id),
        .muldiv_busy     (muldiv_busy)
    );

    always #5 clk = ~clk;

    // ---------------- model: who occupies EX, MEM, WB ----------------
    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       we;
        logic       ld;
    } m_ent_t;

    m_ent_t     m_pipe [3] = '{default: '0};
    int         m_busy_left = 0;
    logic [1:0] m_sel1 = 2'd0, m_sel2 = 2'd0;
    logic       m_b, m_t, m_lu;
    logic [1:0] m_n1, m_n2;
    logic       e_busy, e_flush, e_lu;

    function automatic logic m_writes(input m_ent_t e, input logic [4:0] r);
        return e.v && e.we && (e.rd == r) && (r != 5'd0);
    endfunction

    function automatic logic m_load_use();
        if (!id_valid) return 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (m_pipe[i].ld && ((id_use_rs1 && m_writes(m_pipe[i], id_rs1)) ||
                                 (id_use_rs2 && m_writes(m_pipe[i], id_rs2))))
                return 1'b1;
        end
        return 1'b0;
    endfunction

    // Youngest producer decides: an ALU result one stage ahead comes from MEM,
    // two stages ahead from WB; a load is only usable once it reached WB.
    function automatic logic [1:0] m_fwd(input logic used, input logic [4:0] r);
        if (!id_valid || !used || id_is_branch) return 2'd0;
        for (int i = 0; i < 3; i++) begin
            if (m_writes(m_pipe[i], r)) begin
                if (m_pipe[i].ld) return (i == 2) ? 2'd2 : 2'd0;
                return (i == 0) ? 2'd1 : ((i == 1) ? 2'd2 : 2'd0);
            end
        end
        return 2'd0;
    endfunction

    // Advance the model on each clock edge, reset asynchronously.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_pipe      = '{default: '0};
            m_busy_left = 0;
            m_sel1      = 2'd0;
            m_sel2      = 2'd0;
        end else begin
            m_b  = (m_busy_left > 0);
            m_t  = ex_branch_taken && !m_b;
            m_lu = m_load_use();
            m_n1 = m_fwd(id_use_rs1, id_rs1);
            m_n2 = m_fwd(id_use_rs2, id_rs2);
            m_pipe[2] = m_pipe[1];
            if (m_b) begin
                m_pipe[1] = '0;
                m_busy_left--;
            end else begin
                m_pipe[1] = m_pipe[0];
                if (!m_lu && !m_t) begin
                    m_pipe[0] = '{v: id_valid, rd: id_rd, we: id_we, ld: id_is_load};
                    m_sel1 = m_n1;
                    m_sel2 = m_n2;
                    if (id_valid && id_is_muldiv) m_busy_left = LAT - 1;
                end else begin
                    m_pipe[0] = '0;
                    m_sel1 = 2'd0;
                    m_sel2 = 2'd0;
                end
            end
        end
    end

    task automatic check_output(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output against the model mid-cycle.
    always @(negedge clk) begin
        e_busy  = (m_busy_left > 0);
        e_flush = ex_branch_taken && !e_busy;
        e_lu    = m_load_use();
        check_output("model_stall",  stall_if_id,    e_busy || (e_lu && !e_flush));
        check_output("model_bubble", bubble_ex,      !e_busy && (e_flush || e_lu));
        check_output("model_flush",  flush_if_id,    e_flush);
        check_output("model_busy",   muldiv_busy,    e_busy);
        check_output("model_rs1",    rs1_forwarding, m_sel1);
        check_output("model_rs2",    rs2_forwarding, m_sel2);
    end

    // ---------------- stimulus ----------------
    task automatic apply_stimulus(input logic v, input logic [4:0] rd,
                                  input logic [4:0] rs1, input logic u1,
                                  input logic [4:0] rs2, input logic u2,
                                  input logic we, input logic ld, input logic md,
                                  input logic br, input logic tk);
        id_valid = v;      id_rd = rd;
        id_rs1 = rs1;      id_use_rs1 = u1;
        id_rs2 = rs2;      id_use_rs2 = u2;
        id_we = we;        id_is_load = ld;
        id_is_muldiv = md; id_is_branch = br;
        ex_branch_taken = tk;
    endtask

    // Hold an instruction in ID until it advances; return at posedge+1 with it in EX.
    task automatic issue(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2, input logic we,
                         input logic ld, input logic md, input logic br,
                         output int stalls, output int busies, output int bubbles);
        apply_stimulus(1'b1, rd, rs1, u1, rs2, u2, we, ld, md, br, 1'b0);
        stalls = 0; busies = 0; bubbles = 0;
        @(negedge clk);
        while (stall_if_id === 1'b1 && stalls < 20) begin
            stalls++;
            if (muldiv_busy) busies++;
            if (bubble_ex) bubbles++;
            @(negedge clk);
        end
        if (stalls >= 20) begin
            checks++;
            errors++;
            $display("[TB] FAIL stall_bound actual=%0d stall cycles required=<20", stalls);
        end
        @(posedge clk);
        #1;
    endtask

    int s, b, bb;

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        // Reset state
        rstn = 1'b0;
        @(negedge clk);
        check_output("rst_stall", stall_if_id, 0);
        check_output("rst_bubble", bubble_ex, 0);
        check_output("rst_flush", flush_if_id, 0);
        check_output("rst_busy", muldiv_busy, 0);
        check_output("rst_rs1", rs1_forwarding, 0);
        check_output("rst_rs2", rs2_forwarding, 0);
        @(posedge clk); #1;
        rstn = 1'b1;

        // add x5,x1,x2 ; sub x6,x5,x3
        issue(5'd5, 5'd1, 1, 5'd2, 1, 1, 0, 0, 0, s, b, bb);
        issue(5'd6, 5'd5, 1, 5'd3, 1, 1, 0, 0, 0, s, b, bb);
        check_output("mem_fwd_stalls", 2'(s), 0);
        check_output("mem_fwd_rs1", rs1_forwarding, 1);
        check_output("mem_fwd_rs2", rs2_forwarding, 0);

        // add x5 ; nop ; or x7,x0,x5
        issue(5'd5, 5'd1, 1, 5'd2, 1, 1, 0, 0, 0, s, b, bb);
        issue(5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, s, b, bb);
        issue(5'd7, 5'd0, 1, 5'd5, 1, 1, 0, 0, 0, s, b, bb);
        check_output("wb_fwd_rs2", rs2_forwarding, 2);
        check_output("wb_fwd_rs1", rs1_forwarding, 0);

        // add x0 ; nop ; or x7,x0,x0  (x0 never forwards)
        issue(5'd0, 5'd1, 1, 5'd2, 1, 1, 0, 0, 0, s, b, bb);
        issue(5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, s, b, bb);
        issue(5'd7, 5'd0, 1, 5'd0, 1, 1, 0, 0, 0, s, b, bb);
        check_output("x0_fwd_rs2", rs2_forwarding, 0);

        // ld x8 ; add x9,x8,x8
        issue(5'd8, 5'd1, 1, 5'd0, 0, 1, 1, 0, 0, s, b, bb);
        issue(5'd9, 5'd8, 1, 5'd8, 1, 1, 0, 0, 0, s, b, bb);
        check_output("ld_use_stalls", 2'(s), 2);
        check_output("ld_use_bubbles", 2'(bb), 2);
        check_output("ld_use_rs1", rs1_forwarding, 2);
        check_output("ld_use_rs2", rs2_forwarding, 2);

        // mul x10 ; add x11,x10,x0
        issue(5'd10, 5'd1, 1, 5'd2, 1, 1, 0, 1, 0, s, b, bb);
        issue(5'd11, 5'd10, 1, 5'd0, 1, 1, 0, 0, 0, s, b, bb);
        check_output("mul_stalls", 2'(s), 3);
        check_output("mul_busy_cycles", 2'(b), 3);
        check_output("mul_rs1", rs1_forwarding, 1);
        check_output("mul_rs2", rs2_forwarding, 0);

        // add x5 ; ld x8,0(x5) ; add x9,x8,x8 squashed by a taken branch
        issue(5'd5, 5'd1, 1, 5'd2, 1, 1, 0, 0, 0, s, b, bb);
        issue(5'd8, 5'd5, 1, 5'd0, 0, 1, 1, 0, 0, s, b, bb);
        check_output("ld_addr_rs1", rs1_forwarding, 1);
        apply_stimulus(1'b1, 5'd9, 5'd8, 1, 5'd8, 1, 1, 0, 0, 0, 1'b1);
        @(negedge clk);
        check_output("br_flush", flush_if_id, 1);
        check_output("br_stall", stall_if_id, 0);
        check_output("br_bubble", bubble_ex, 1);
        @(posedge clk); #1;
        check_output("br_rs1", rs1_forwarding, 0);
        check_output("br_rs2", rs2_forwarding, 0);
        issue(5'd12, 5'd9, 1, 5'd0, 0, 1, 0, 0, 0, s, b, bb);
        check_output("br_squashed_rs1", rs1_forwarding, 0);
        check_output("br_squashed_stalls", 2'(s), 0);

        // branch compare and unused source carry no forwarding
        issue(5'd13, 5'd1, 1, 5'd2, 1, 1, 0, 0, 0, s, b, bb);
        issue(5'd0, 5'd13, 1, 5'd13, 1, 0, 0, 0, 1, s, b, bb);
        check_output("branch_rs1", rs1_forwarding, 0);
        issue(5'd14, 5'd1, 1, 5'd2, 1, 1, 0, 0, 0, s, b, bb);
        issue(5'd15, 5'd14, 0, 5'd14, 1, 1, 0, 0, 0, s, b, bb);
        check_output("unused_rs1", rs1_forwarding, 0);
        check_output("used_rs2", rs2_forwarding, 1);

        // add x5 ; mul x10,x5 ; reset while busy
        issue(5'd5, 5'd1, 1, 5'd2, 1, 1, 0, 0, 0, s, b, bb);
        issue(5'd10, 5'd5, 1, 5'd0, 0, 1, 0, 1, 0, s, b, bb);
        check_output("mul2_rs1", rs1_forwarding, 1);
        apply_stimulus(1'b0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, 1'b0);
        @(negedge clk);
        check_output("mul2_busy", muldiv_busy, 1);
        #2 rstn = 1'b0;
        #1;
        check_output("arst_busy", muldiv_busy, 0);
        check_output("arst_stall", stall_if_id, 0);
        check_output("arst_rs1", rs1_forwarding, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        issue(5'd11, 5'd10, 1, 5'd0, 0, 1, 0, 0, 0, s, b, bb);
        check_output("post_rst_stalls", 2'(s), 0);
        check_output("post_rst_rs1", rs1_forwarding, 0);

        apply_stimulus(1'b0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
